div128_multi: RTL and testbench
===============================

DIV128_MULTI -- requirements
Module: div128_multi

Interface
REQ-001 Parameter: W, default 64, divisor/quotient/remainder width; dividend is 2*W.
REQ-002 clk  input  1  rising-edge clock, the block's only clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; operands sampled on the edge where start=1 and the block accepts.
REQ-005 N  input  2*W  dividend (unsigned); width matches a full W x W product.
REQ-006 D  input  W  divisor (unsigned).
REQ-007 Q  output  W  quotient register.
REQ-008 R  output  W  remainder register.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse; Q/R/ovf/dz are valid from this cycle onward.
REQ-011 ovf  output  1  quotient does not fit in W bits.
REQ-012 dz  output  1  divide by zero.

Function
REQ-013 States:
- IDLE: start=1 latches N and D; D==0 goes to ERR; N[2W-1:W] >= D goes to ERR; otherwise goes to CALC.
- CALC: exactly W edges, then goes to FIN.
- ERR: one edge, then goes to FIN.
- FIN: one cycle, then goes to IDLE.
REQ-014 Start is accepted in IDLE and in FIN; a start in FIN behaves as a start in IDLE and the FSM goes directly to CALC or ERR.
REQ-015 CALC is unsigned restoring division, one quotient bit per edge, MSB first, with a W+1-bit partial remainder.
REQ-016 Normal-path latency: done is high in the cycle ending on the (W+1)-th edge after the accepting edge (65 cycles for W=64).
REQ-017 Error-path latency: done is high in the cycle ending on the 2nd edge after the accepting edge.
REQ-018 done and FIN coincide; done is high for exactly one cycle per accepted start.
REQ-019 busy is high in CALC and ERR and low in IDLE and FIN.
REQ-020 Normal-path result: Q = N / D, R = N % D, ovf=0, dz=0.
REQ-021 D==0 result: Q = all ones, R = N[W-1:0], dz=1, ovf=0.
REQ-022 Overflow result (D!=0 and N[2W-1:W] >= D): Q = all ones, R = 0, ovf=1, dz=0.
REQ-023 Q, R, ovf and dz hold their values from the done cycle until the next done; internal working registers are separate from Q and R.
REQ-024 Input changes on N and D after the accepting edge have no effect on the running operation.

Reset
REQ-025 Asserting rst_n low, at any time including mid-CALC, immediately forces the FSM to IDLE and Q=0, R=0, busy=0, done=0, ovf=0, dz=0.
REQ-026 A start that coincides with rst_n low is ignored; the first start after deassertion is accepted normally.

Configuration
REQ-027 Macro DIV128_MULTI_RESTART_EN controls restart behaviour while busy.
- Defined: start=1 while busy aborts the current operation without a done pulse, relatches N and D, and restarts per REQ-013; latency is counted from the new accepting edge.
- Not defined: start is ignored while busy.

Structure
REQ-028 Package div128_pkg holds:
- the FSM state enum {IDLE, CALC, ERR, FIN};
- the default width constant (64);
- the iteration counter width localparam, $clog2(W+1).
REQ-029 One combinational sub-module, div_step, performs a single restoring step: it takes the partial remainder, the next dividend bit and D, and returns the new partial remainder and the quotient bit.

Verification
REQ-030 N=100, D=7 -> done exactly 65 cycles after start, Q=14, R=2, ovf=0, dz=0.
REQ-031 N=0xFFFFFFFFFFFFFFFE_0000000000000001, D=0xFFFFFFFFFFFFFFFF -> Q=0xFFFFFFFFFFFFFFFF, R=0, ovf=0.
REQ-032 N=0x...1234, D=0 -> done 2 cycles after start, dz=1, Q=all ones, R=N[63:0].
REQ-033 N=0x0000000000000005_0000000000000000, D=5 -> done 2 cycles after start, ovf=1, Q=all ones, R=0.
REQ-034 rst_n pulsed low at cycle 30 of CALC -> all outputs 0 immediately, no done pulse.
- Then start N=9, D=3 -> Q=3, R=0 after 65 cycles.
REQ-035 Second start (N=50, D=5) at cycle 20 of CALC:
- With DIV128_MULTI_RESTART_EN: one done, 65 cycles after the second start, Q=10, R=0.
- Without it: one done at the original time, carrying the first operation's result.

Source files
------------

// File: rtl/div128_pkg.sv
// Shared types and constants for the multi-cycle 2W/W restoring divider.
package div128_pkg;

    // Default divisor/quotient/remainder width; the dividend is twice this.
    localparam int unsigned DEF_W = 64;

    // Width of an iteration counter that must reach w.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEF_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ERR  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract D if it fits.
module div_step #(
    parameter int unsigned W = 64
) (
    input  logic [W:0]   rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] d,
    output logic [W:0]   rem_out,
    output logic         q_bit
);

    logic [W+1:0] trial;
    logic [W+1:0] diff;

    // Trial subtraction is carried one bit wider so no remainder bit is discarded.
    always_comb begin
        trial   = {rem_in, bit_in};
        diff    = trial - (W+2)'(d);
        q_bit   = (trial >= (W+2)'(d));
        rem_out = q_bit ? (W+1)'(diff) : (W+1)'(trial);
    end

endmodule

// File: rtl/div128_multi.sv
// Multi-cycle unsigned divider: 2W-bit dividend by W-bit divisor, one quotient bit per cycle.
// Optional macro DIV128_MULTI_RESTART_EN: a start while busy aborts and restarts the operation.
module div128_multi
    import div128_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] N,
    input  logic [W-1:0]   D,
    output logic [W-1:0]   Q,
    output logic [W-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic           ovf,
    output logic           dz
);

    localparam int unsigned CW = cnt_width(W);

    state_t         state_q;
    state_t         state_d;

    logic           can_accept_c;
    logic           accept_c;
    logic           err_c;
    logic           load_c;
    logic           step_c;
    logic           fin_calc_c;
    logic           fin_err_c;

    logic [W-1:0]   d_r;
    logic [W-1:0]   n_lo;
    logic [W:0]     rem_q;
    logic [W-1:0]   qw;
    logic [CW-1:0]  cnt;
    logic           dz_w;
    logic           ovf_w;

    logic [W:0]     rem_nxt;
    logic           qb;

`ifdef DIV128_MULTI_RESTART_EN
    assign can_accept_c = 1'b1;
`else
    assign can_accept_c = (state_q == IDLE) || (state_q == FIN);
`endif

    assign accept_c = start && can_accept_c;
    assign err_c    = (D == '0) || (N[2*W-1:W] >= D);

    div_step #(.W(W)) u_step (
        .rem_in  (rem_q),
        .bit_in  (n_lo[W-1]),
        .d       (d_r),
        .rem_out (rem_nxt),
        .q_bit   (qb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an accepted start overrides whatever the FSM was doing.
    always_comb begin
        state_d = state_q;
        if (accept_c) begin
            state_d = err_c ? ERR : CALC;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                CALC:    if (cnt == CW'(W - 1)) state_d = FIN;
                ERR:     state_d = FIN;
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath control decoded from the current and next state.
    always_comb begin
        load_c     = accept_c;
        step_c     = (state_q == CALC) && !accept_c;
        fin_calc_c = (state_q == CALC) && (state_d == FIN);
        fin_err_c  = (state_q == ERR)  && (state_d == FIN);
    end

    // Working registers: latched operands, partial remainder, quotient shifter, step count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r   <= '0;
            n_lo  <= '0;
            rem_q <= '0;
            qw    <= '0;
            cnt   <= '0;
            dz_w  <= 1'b0;
            ovf_w <= 1'b0;
        end else if (load_c) begin
            d_r   <= D;
            n_lo  <= N[W-1:0];
            rem_q <= {1'b0, N[2*W-1:W]};
            qw    <= '0;
            cnt   <= '0;
            dz_w  <= (D == '0);
            ovf_w <= (D != '0) && (N[2*W-1:W] >= D);
        end else if (step_c) begin
            rem_q <= rem_nxt;
            n_lo  <= W'({n_lo, 1'b0});
            qw    <= W'({qw, qb});
            cnt   <= cnt + CW'(1);
        end
    end

    // Visible results: updated only on entry to FIN, held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q    <= '0;
            R    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            ovf  <= 1'b0;
            dz   <= 1'b0;
        end else begin
            busy <= (state_d == CALC) || (state_d == ERR);
            done <= (state_d == FIN);
            if (fin_calc_c) begin
                Q   <= W'({qw, qb});
                R   <= rem_nxt[W-1:0];
                ovf <= 1'b0;
                dz  <= 1'b0;
            end else if (fin_err_c) begin
                Q   <= '1;
                R   <= dz_w ? n_lo : '0;
                ovf <= ovf_w;
                dz  <= dz_w;
            end
        end
    end

endmodule

// File: tb/tb_div128_multi.sv
// Self-checking bench for div128_multi (W=64) against a plain-arithmetic reference model.
module tb_div128_multi;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] N;
    logic [63:0]  D;
    logic [63:0]  Q;
    logic [63:0]  R;
    logic         busy;
    logic         done;
    logic         ovf;
    logic         dz;

    int n_checks;
    int n_fails;

    div128_multi #(.W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .N     (N),
        .D     (D),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result and latency (cycles from accept to done) from the rules alone.
    task automatic model(input logic [127:0] n, input logic [63:0] d,
                         output logic [63:0] q, output logic [63:0] r,
                         output logic o, output logic z, output int lat);
        logic [127:0] q128;
        logic [127:0] r128;
        logic [63:0]  hi;
        hi = n[127:64];
        if (d == 64'd0) begin
            q = '1; r = n[63:0]; o = 1'b0; z = 1'b1; lat = 2;
        end else if (hi >= d) begin
            q = '1; r = '0; o = 1'b1; z = 1'b0; lat = 2;
        end else begin
            q128 = n / {64'd0, d};
            r128 = n % {64'd0, d};
            q = q128[63:0]; r = r128[63:0]; o = 1'b0; z = 1'b0; lat = 65;
        end
    endtask

    // Issue one operation from a negedge; returns at the negedge where done is seen (or timeout).
    task automatic run_op(input logic [127:0] n, input logic [63:0] d,
                          output int lat, output logic [63:0] q, output logic [63:0] r,
                          output logic o, output logic z, output logic b1);
        start = 1'b1; N = n; D = d;
        @(negedge clk);
        start = 1'b0;
        N = {$urandom, $urandom, $urandom, $urandom};
        D = {$urandom, $urandom};
        lat = 1;
        b1 = busy;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        q = Q; r = R; o = ovf; z = dz;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; N = '0; D = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({Q, R, busy, done, ovf, dz} !== '0) begin
            n_fails++;
            $display("FAIL reset_state: got Q=%h R=%h busy=%b done=%b ovf=%b dz=%b required all zero",
                     Q, R, busy, done, ovf, dz);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [127:0] vn [4];
        logic [63:0]  vd [4];
        logic [63:0]  q, r, eq, er;
        logic         o, z, eo, ez, b1;
        int           lat, elat;
        vn[0] = 128'd100;                                          vd[0] = 64'd7;
        vn[1] = {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001}; vd[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        vn[2] = {64'h0000_0000_0000_BEEF, 64'h0000_0000_0000_1234}; vd[2] = 64'd0;
        vn[3] = {64'h0000_0000_0000_0005, 64'h0000_0000_0000_0000}; vd[3] = 64'd5;
        for (int i = 0; i < 4; i++) begin
            model(vn[i], vd[i], eq, er, eo, ez, elat);
            run_op(vn[i], vd[i], lat, q, r, o, z, b1);
            n_checks++;
            if (lat !== elat) begin n_fails++; $display("FAIL vec%0d_latency: got %0d required %0d", i, lat, elat); end
            n_checks++;
            if (q !== eq) begin n_fails++; $display("FAIL vec%0d_Q: got %h required %h", i, q, eq); end
            n_checks++;
            if (r !== er) begin n_fails++; $display("FAIL vec%0d_R: got %h required %h", i, r, er); end
            n_checks++;
            if ({o, z} !== {eo, ez}) begin n_fails++; $display("FAIL vec%0d_flags: got ovf=%b dz=%b required ovf=%b dz=%b", i, o, z, eo, ez); end
            n_checks++;
            if (b1 !== 1'b1) begin n_fails++; $display("FAIL vec%0d_busy: got %b required 1", i, b1); end
            @(negedge clk);
            n_checks++;
            if ({done, Q, R} !== {1'b0, eq, er}) begin
                n_fails++;
                $display("FAIL vec%0d_hold: got done=%b Q=%h R=%h required done=0 Q=%h R=%h", i, done, Q, R, eq, er);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] n;
        logic [63:0]  d, hi, rnd;
        logic [63:0]  q, r, eq, er;
        logic         o, z, eo, ez, b1;
        int           lat, elat, mode;
        for (int i = 0; i < 25; i++) begin
            mode = int'($urandom_range(0, 9));
            rnd  = {$urandom, $urandom};
            d    = (mode == 2) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
            if (mode == 0) d = '0;
            else if (d == '0) d = 64'd1;
            if (mode == 1) hi = (rnd >= d) ? rnd : d;
            else if (mode == 0) hi = rnd;
            else hi = rnd % d;
            n = {hi, $urandom, $urandom};
            model(n, d, eq, er, eo, ez, elat);
            run_op(n, d, lat, q, r, o, z, b1);
            n_checks++;
            if (lat !== elat) begin n_fails++; $display("FAIL rnd%0d_latency: got %0d required %0d", i, lat, elat); end
            n_checks++;
            if ({q, r, o, z} !== {eq, er, eo, ez}) begin
                n_fails++;
                $display("FAIL rnd%0d_result: N=%h D=%h got Q=%h R=%h ovf=%b dz=%b required Q=%h R=%h ovf=%b dz=%b",
                         i, n, d, q, r, o, z, eq, er, eo, ez);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] vn [3];
        logic [63:0]  vd [3];
        logic [63:0]  q, r, eq, er;
        logic         o, z, eo, ez, b1;
        int           lat, elat;
        vn[0] = 128'd1000;   vd[0] = 64'd0;
        vn[1] = 128'd12345;  vd[1] = 64'd100;
        vn[2] = {64'd9, 64'd0}; vd[2] = 64'd3;
        for (int i = 0; i < 3; i++) begin
            model(vn[i], vd[i], eq, er, eo, ez, elat);
            run_op(vn[i], vd[i], lat, q, r, o, z, b1);
            n_checks++;
            if ({lat, b1} !== {elat, 1'b1}) begin
                n_fails++;
                $display("FAIL b2b%0d_timing: got lat=%0d busy=%b required lat=%0d busy=1", i, lat, b1, elat);
            end
            n_checks++;
            if ({q, r, o, z} !== {eq, er, eo, ez}) begin
                n_fails++;
                $display("FAIL b2b%0d_result: got Q=%h R=%h ovf=%b dz=%b required Q=%h R=%h ovf=%b dz=%b",
                         i, q, r, o, z, eq, er, eo, ez);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [63:0] q, r;
        logic        o, z, b1, saw_done;
        int          lat;
        start = 1'b1; N = 128'd100; D = 64'd7;
        @(negedge clk);
        start = 1'b0;
        saw_done = 1'b0;
        for (int k = 1; k < 30; k++) begin
            saw_done |= done;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({Q, R, busy, done, ovf, dz, saw_done} !== '0) begin
            n_fails++;
            $display("FAIL midreset_clear: got Q=%h R=%h busy=%b done=%b ovf=%b dz=%b early_done=%b required all zero",
                     Q, R, busy, done, ovf, dz, saw_done);
        end
        start = 1'b1; N = 128'd77; D = 64'd5;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fails++;
            $display("FAIL start_in_reset: got busy=%b done=%b required 0 0", busy, done);
        end
        run_op(128'd9, 64'd3, lat, q, r, o, z, b1);
        n_checks++;
        if ({lat, q, r, o, z} !== {65, 64'd3, 64'd0, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL after_reset_op: got lat=%0d Q=%h R=%h ovf=%b dz=%b required lat=65 Q=3 R=0 ovf=0 dz=0",
                     lat, q, r, o, z);
        end
        @(negedge clk);
    endtask

    task automatic test_restart();
        int          dones, done_k, exp_k;
        logic [63:0] q, r, eq, er;
        dones = 0; done_k = -1; q = '0; r = '0;
`ifdef DIV128_MULTI_RESTART_EN
        exp_k = 85; eq = 64'd10; er = 64'd0;
`else
        exp_k = 65; eq = 64'd14; er = 64'd2;
`endif
        start = 1'b1; N = 128'd100; D = 64'd7;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            if (done === 1'b1) begin
                dones++; done_k = k; q = Q; r = R;
            end
            if (k == 20) begin start = 1'b1; N = 128'd50; D = 64'd5; end
            else start = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (dones !== 1) begin n_fails++; $display("FAIL restart_done_count: got %0d required 1", dones); end
        n_checks++;
        if (done_k !== exp_k) begin n_fails++; $display("FAIL restart_done_time: got %0d required %0d", done_k, exp_k); end
        n_checks++;
        if ({q, r} !== {eq, er}) begin
            n_fails++;
            $display("FAIL restart_result: got Q=%h R=%h required Q=%h R=%h", q, r, eq, er);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
